// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the FIFO pointer/flag controller.
package fifo_pkg;

  // The occupancy count needs one bit more than an address to represent DEPTH.
  localparam int unsigned CNT_EXTRA_W = 1;

  // Number of entries addressed by an aw-bit pointer.
  function automatic int unsigned fifo_depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/fifo_ptr_ctr.sv
// Wrapping ADDR_WIDTH-bit pointer: increments on inc, clears synchronously on clr.
module fifo_ptr_ctr #(
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] ptr
);

  logic [ADDR_WIDTH-1:0] r_ptr;

  // Pointer register; natural width overflow gives the DEPTH-1 -> 0 wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (clr) begin
      r_ptr <= '0;
    end else if (inc) begin
      r_ptr <= r_ptr + ADDR_WIDTH'(1);
    end
  end

  assign ptr = r_ptr;

endmodule

// File: rtl/fifo_ctrl.sv
// Single-clock FIFO controller: accept gating, RAM enables/addresses,
// occupancy count, watermark flags and sticky overflow/underflow errors.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned AFULL_LEVEL  = 12,
  parameter int unsigned AEMPTY_LEVEL = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic                              push,
  input  logic                              pop,
  input  logic                              clr_err,
  output logic                              wr_en,
  output logic [ADDR_WIDTH-1:0]             wr_addr,
  output logic                              rd_en,
  output logic [ADDR_WIDTH-1:0]             rd_addr,
  output logic [ADDR_WIDTH+CNT_EXTRA_W-1:0] count,
  output logic                              full,
  output logic                              empty,
  output logic                              almost_full,
  output logic                              almost_empty,
  output logic                              overflow,
  output logic                              underflow
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int unsigned CNT_W = ADDR_WIDTH + CNT_EXTRA_W;

  logic [CNT_W-1:0]      r_count;
  logic                  r_overflow;
  logic                  r_underflow;
  logic [ADDR_WIDTH-1:0] w_wr_ptr;
  logic [ADDR_WIDTH-1:0] w_rd_ptr;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push_ok;
  logic                  w_pop_ok;
  logic                  w_ovf_set;
  logic                  w_udf_set;

  // Flags come from the registered count only, so they never glitch with requests.
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // Flush blocks both accepts; a request hitting full/empty is rejected and
  // raises the matching error instead (ignored requests during flush do not).
  assign w_push_ok = push & ~w_full  & ~flush;
  assign w_pop_ok  = pop  & ~w_empty & ~flush;
  assign w_ovf_set = push & w_full  & ~flush;
  assign w_udf_set = pop  & w_empty & ~flush;

  fifo_ptr_ctr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (w_push_ok),
    .ptr   (w_wr_ptr)
  );

  fifo_ptr_ctr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (w_pop_ok),
    .ptr   (w_rd_ptr)
  );

  // Occupancy: simultaneous accepted push and pop cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else if (w_push_ok && !w_pop_ok) begin
      r_count <= r_count + CNT_W'(1);
    end else if (w_pop_ok && !w_push_ok) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= w_ovf_set | (r_overflow  & ~clr_err);
      r_underflow <= w_udf_set | (r_underflow & ~clr_err);
    end
  end

  assign wr_en        = w_push_ok;
  assign wr_addr      = w_wr_ptr;
  assign rd_en        = w_pop_ok;
  assign rd_addr      = w_rd_ptr;
  assign count        = r_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= CNT_W'(AFULL_LEVEL));
  assign almost_empty = (r_count <= CNT_W'(AEMPTY_LEVEL));
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

`ifdef FORMAL
  // Structural invariants of the pointer/count relationship.
  always_comb begin
    if (rst_n) begin
      assert (r_count <= CNT_W'(DEPTH));
      assert (ADDR_WIDTH'(w_wr_ptr - w_rd_ptr) == r_count[ADDR_WIDTH-1:0]);
      assert (!(w_full && w_empty));
      assert (!wr_en || !w_full);
      assert (!rd_en || !w_empty);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: per-cycle comparison against an
// occupancy-level model plus directed literal checks.
module tb_fifo_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;
  localparam int AEMPT = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic          clr_err = 1'b0;
  logic          wr_en, rd_en;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [AW:0]   count;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;

  int n_checks = 0;
  int n_err    = 0;

  fifo_ctrl #(.ADDR_WIDTH(AW), .AFULL_LEVEL(AFULL), .AEMPTY_LEVEL(AEMPT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .push         (push),
    .pop          (pop),
    .clr_err      (clr_err),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: occupancy and pointers as plain integers.
  int m_cnt = 0;
  int m_wp  = 0;
  int m_rp  = 0;
  bit m_ovf = 1'b0;
  bit m_udf = 1'b0;

  always @(negedge rst_n) begin
    m_cnt = 0; m_wp = 0; m_rp = 0; m_ovf = 1'b0; m_udf = 1'b0;
  end

  always @(posedge clk) begin
    bit acc_w, acc_r, set_o, set_u;
    if (rst_n) begin
      set_o = push && !flush && (m_cnt == DEPTH);
      set_u = pop  && !flush && (m_cnt == 0);
      if (flush) begin
        m_cnt = 0; m_wp = 0; m_rp = 0;
      end else begin
        acc_w = push && (m_cnt < DEPTH);
        acc_r = pop  && (m_cnt > 0);
        m_cnt = m_cnt + int'(acc_w) - int'(acc_r);
        m_wp  = (m_wp + int'(acc_w)) % DEPTH;
        m_rp  = (m_rp + int'(acc_r)) % DEPTH;
      end
      m_ovf = set_o || (m_ovf && !clr_err);
      m_udf = set_u || (m_udf && !clr_err);
    end
  end

  // Compare every cycle, away from the rising edge.
  always @(negedge clk) begin
    chk("wr_en",        wr_en,        32'(push && !flush && m_cnt < DEPTH));
    chk("rd_en",        rd_en,        32'(pop && !flush && m_cnt > 0));
    chk("wr_addr",      wr_addr,      32'(m_wp));
    chk("rd_addr",      rd_addr,      32'(m_rp));
    chk("count",        count,        32'(m_cnt));
    chk("full",         full,         32'(m_cnt == DEPTH));
    chk("empty",        empty,        32'(m_cnt == 0));
    chk("almost_full",  almost_full,  32'(m_cnt >= AFULL));
    chk("almost_empty", almost_empty, 32'(m_cnt <= AEMPT));
    chk("overflow",     overflow,     32'(m_ovf));
    chk("underflow",    underflow,    32'(m_udf));
  end

  // One clock with the given requests; returns idle, 2 time units after the edge.
  task automatic step(input bit p, input bit q, input bit f, input bit c);
    push = p; pop = q; flush = f; clr_err = c;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0;
    #1;
  endtask

  initial begin
    // Reset and idle
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_rd_addr", rd_addr, 0);

    // Fill
    for (int i = 0; i < 16; i++) begin
      push = 1'b1;
      #1;
      chk("fill_wr_en", wr_en, 1);
      chk("fill_wr_addr", wr_addr, 32'(i));
      @(posedge clk);
      #1 push = 1'b0;
      #1;
      if (i == 10) chk("afull_at_11", almost_full, 0);
      if (i == 11) chk("afull_at_12", almost_full, 1);
    end
    chk("fill_count", count, 16);
    chk("fill_full", full, 1);
    chk("fill_wrap", wr_addr, 0);
    push = 1'b1;
    #1;
    chk("push_full_wr_en", wr_en, 0);
    @(posedge clk);
    #1 push = 1'b0;
    #1;
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 16);

    // Drain
    for (int i = 0; i < 16; i++) begin
      pop = 1'b1;
      #1;
      chk("drain_rd_en", rd_en, 1);
      chk("drain_rd_addr", rd_addr, 32'(i));
      @(posedge clk);
      #1 pop = 1'b0;
      #1;
    end
    chk("drain_empty", empty, 1);
    chk("drain_wrap", rd_addr, 0);
    pop = 1'b1;
    #1;
    chk("pop_empty_rd_en", rd_en, 0);
    @(posedge clk);
    #1 pop = 1'b0;
    #1;
    chk("udf_set", underflow, 1);
    chk("ovf_held", overflow, 1);
    step(0, 0, 0, 1);
    chk("clr_ovf", overflow, 0);
    chk("clr_udf", underflow, 0);

    // Simultaneous push+pop at full
    for (int i = 0; i < 16; i++) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("pp_full_count", count, 15);
    chk("pp_full_ovf", overflow, 1);
    chk("pp_full_rd_addr", rd_addr, 1);
    chk("pp_full_wr_addr", wr_addr, 0);
    step(0, 0, 0, 1);

    // Simultaneous push+pop at empty
    for (int i = 0; i < 15; i++) step(0, 1, 0, 0);
    chk("pp_pre_empty", count, 0);
    step(1, 1, 0, 0);
    chk("pp_empty_count", count, 1);
    chk("pp_empty_udf", underflow, 1);
    chk("pp_empty_wr_addr", wr_addr, 1);

    // Steady streaming at count=7
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0);
    chk("stream_start_count", count, 7);
    for (int i = 0; i < 20; i++) step(1, 1, 0, 0);
    chk("stream_count", count, 7);
    chk("stream_wr_addr", wr_addr, 11);
    chk("stream_rd_addr", rd_addr, 4);

    // Flush at count=9 with push held
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("pre_flush_count", count, 9);
    push = 1'b1; flush = 1'b1;
    #1;
    chk("flush_wr_en", wr_en, 0);
    @(posedge clk);
    #1 push = 1'b0; flush = 1'b0;
    #1;
    chk("flush_count", count, 0);
    chk("flush_wr_addr", wr_addr, 0);
    chk("flush_rd_addr", rd_addr, 0);
    chk("flush_empty", empty, 1);
    chk("flush_udf_kept", underflow, 1);
    chk("flush_ovf_kept", overflow, 0);

    // Asynchronous reset mid-operation at count=5
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    chk("pre_rst_count", count, 5);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_wr_addr", wr_addr, 0);
    chk("arst_empty", empty, 1);
    chk("arst_aempty", almost_empty, 1);
    chk("arst_full", full, 0);
    chk("arst_afull", almost_full, 0);
    chk("arst_udf", underflow, 0);
    chk("arst_wr_en", wr_en, 0);
    chk("arst_rd_en", rd_en, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("resume_count", count, 2);
    chk("resume_wr_addr", wr_addr, 2);

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
